if_queue: RTL and testbench

IF_QUEUE -- requirements
Module: if_queue

---
 rtl/if_queue.sv | 108 ++++++++++
 tb/tb_if_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/if_queue.sv
// Instruction fetch queue: issues sequential ROM fetches, pairs returned words with
// their PCs, and buffers them for decode. Redirects flush the queue and drop stale responses.
module if_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] rom_addr,
  output logic            rom_ce,
  input  logic            rom_vld,
  input  logic [31:0]     rom_data,
  input  logic            jmp,
  input  logic [XLEN-1:0] jmp_addr,
  input  logic            stall,
  output logic            id_vld,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_is
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_q_pc [DEPTH];
  logic [31:0]     r_q_is [DEPTH];
  logic [XLEN-1:0] r_tag  [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [PW-1:0]   r_tag_wr;
  logic [PW-1:0]   r_tag_rd;
  logic [CW-1:0]   r_occ;
  logic [CW-1:0]   r_inflt;
  logic [CW-1:0]   r_drop;

  logic [CW:0]     w_sum;
  logic            w_issue;
  logic            w_enq;
  logic            w_pop;

  // Occupancy plus in-flight bounds issue so every response always has a queue slot.
  assign w_sum   = {1'b0, r_occ} + {1'b0, r_inflt};
  assign w_issue = rst & ~jmp & (w_sum < DEPTH_W);
  assign w_enq   = rst & ~jmp & rom_vld & (r_drop == '0);
  assign w_pop   = ~jmp & ~stall & (r_occ != '0);

  assign rom_ce   = w_issue;
  assign rom_addr = r_pc;
  assign id_vld   = rst & (r_occ != '0);
  assign id_pc    = rst ? r_q_pc[r_head] : '0;
  assign id_is    = rst ? r_q_is[r_head] : '0;

  // Storage arrays carry no reset; validity is tracked by the counters and pointers.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_tag[r_tag_wr] <= r_pc;
    end
    if (w_enq) begin
      r_q_pc[r_tail] <= r_tag[r_tag_rd];
      r_q_is[r_tail] <= rom_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc     <= RESET_PC;
      r_head   <= '0;
      r_tail   <= '0;
      r_tag_wr <= '0;
      r_tag_rd <= '0;
      r_occ    <= '0;
      r_inflt  <= '0;
      r_drop   <= '0;
    end else begin
      // Tag reads follow every response, dropped or not, to stay aligned with the ROM.
      if (rom_vld) begin
        r_tag_rd <= r_tag_rd + PW'(1);
      end
      if (w_issue) begin
        r_pc     <= r_pc + XLEN'(4);
        r_tag_wr <= r_tag_wr + PW'(1);
      end
      if (jmp) begin
        r_pc    <= jmp_addr;
        r_head  <= '0;
        r_tail  <= '0;
        r_occ   <= '0;
        r_drop  <= r_inflt - CW'(rom_vld);
        r_inflt <= r_inflt - CW'(rom_vld);
      end else begin
        r_inflt <= r_inflt + CW'(w_issue) - CW'(rom_vld);
        if (rom_vld && (r_drop != '0)) begin
          r_drop <= r_drop - CW'(1);
        end
        if (w_enq) begin
          r_tail <= r_tail + PW'(1);
        end
        if (w_pop) begin
          r_head <= r_head + PW'(1);
        end
        r_occ <= r_occ + CW'(w_enq) - CW'(w_pop);
      end
    end
  end

endmodule

// File: tb/tb_if_queue.sv
// Directed bench for if_queue with a ROM model of selectable latency returning data == address.
module tb_if_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr;
  logic        rom_ce;
  logic        rom_vld;
  logic [31:0] rom_data;
  logic        jmp;
  logic [31:0] jmp_addr;
  logic        stall;
  logic        id_vld;
  logic [31:0] id_pc;
  logic [31:0] id_is;

  int checks   = 0;
  int failures = 0;
  int lat      = 1;

  logic [2:0]  pv;
  logic [31:0] pa [3];

  always #5 clk = ~clk;

  if_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk      (clk),
    .rst      (rst),
    .rom_addr (rom_addr),
    .rom_ce   (rom_ce),
    .rom_vld  (rom_vld),
    .rom_data (rom_data),
    .jmp      (jmp),
    .jmp_addr (jmp_addr),
    .stall    (stall),
    .id_vld   (id_vld),
    .id_pc    (id_pc),
    .id_is    (id_is)
  );

  // ROM model: accepts every request, answers after lat cycles, cancels on reset.
  always @(posedge clk) begin
    if (!rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[1:0], rom_ce};
      pa[0] <= rom_addr;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
    end
  end
  assign rom_vld  = pv[lat-1];
  assign rom_data = pa[lat-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt(input logic r, input logic s, input logic j, input logic [31:0] ja);
    @(negedge clk);
    rst      = r;
    stall    = s;
    jmp      = j;
    jmp_addr = ja;
    #1;
  endtask

  initial begin
    int issued;
    int popped;
    int maxo;
    logic [31:0] exp_pc;

    rst = 1'b0; stall = 1'b0; jmp = 1'b0; jmp_addr = '0;

    // Reset state
    nxt(1'b0, 1'b0, 1'b0, 32'h0);
    nxt(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_ce", {31'b0, rom_ce}, 32'h0);
    chk("rst_vld", {31'b0, id_vld}, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_is", id_is, 32'h0);

    // Streaming, latency 1, no stall
    for (int k = 0; k < 10; k++) begin
      nxt(1'b1, 1'b0, 1'b0, 32'h0);
      chk("str_ce", {31'b0, rom_ce}, 32'h1);
      chk("str_addr", rom_addr, 32'(4 * k));
      if (k >= 2) begin
        chk("str_vld", {31'b0, id_vld}, 32'h1);
        chk("str_pc", id_pc, 32'(4 * (k - 2)));
        chk("str_is", id_is, 32'(4 * (k - 2)));
      end else begin
        chk("str_vld0", {31'b0, id_vld}, 32'h0);
      end
    end

    // Stall held from reset, then released
    nxt(1'b0, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 7; k++) begin
      nxt(1'b1, 1'b1, 1'b0, 32'h0);
      if (k < 4) begin
        chk("stl_ce", {31'b0, rom_ce}, 32'h1);
        chk("stl_addr", rom_addr, 32'(4 * k));
      end else begin
        chk("stl_ce0", {31'b0, rom_ce}, 32'h0);
      end
      if (k >= 2) begin
        chk("stl_vld", {31'b0, id_vld}, 32'h1);
        chk("stl_pc", id_pc, 32'h0);
      end
    end
    for (int k = 7; k < 12; k++) begin
      nxt(1'b1, 1'b0, 1'b0, 32'h0);
      chk("rel_pc", id_pc, 32'(4 * (k - 7)));
      if (k == 7) chk("rel_ce0", {31'b0, rom_ce}, 32'h0);
      if (k == 8) chk("rel_addr16", rom_addr, 32'h10);
      if (k == 9) chk("rel_addr20", rom_addr, 32'h14);
    end

    // jmp with response and pop in the same cycle, then back-to-back jmps
    nxt(1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) nxt(1'b1, 1'b0, 1'b0, 32'h0);
    nxt(1'b1, 1'b0, 1'b1, 32'h200);
    chk("j1_vld_in", {31'b0, id_vld}, 32'h1);
    chk("j1_ce", {31'b0, rom_ce}, 32'h0);
    nxt(1'b1, 1'b0, 1'b0, 32'h0);
    chk("j1_flush", {31'b0, id_vld}, 32'h0);
    chk("j1_addr", rom_addr, 32'h200);
    chk("j1_ce1", {31'b0, rom_ce}, 32'h1);
    nxt(1'b1, 1'b0, 1'b0, 32'h0);
    chk("j1_vld_wait", {31'b0, id_vld}, 32'h0);
    chk("j1_addr2", rom_addr, 32'h204);
    nxt(1'b1, 1'b0, 1'b0, 32'h0);
    chk("j1_pc", id_pc, 32'h200);
    nxt(1'b1, 1'b0, 1'b0, 32'h0);
    chk("j1_pc2", id_pc, 32'h204);
    nxt(1'b1, 1'b0, 1'b1, 32'h300);
    nxt(1'b1, 1'b0, 1'b1, 32'h400);
    chk("j2_ce", {31'b0, rom_ce}, 32'h0);
    nxt(1'b1, 1'b0, 1'b0, 32'h0);
    chk("j2_addr", rom_addr, 32'h400);
    nxt(1'b1, 1'b0, 1'b0, 32'h0);
    chk("j2_vld", {31'b0, id_vld}, 32'h0);
    nxt(1'b1, 1'b0, 1'b0, 32'h0);
    chk("j2_pc", id_pc, 32'h400);

    // Reset pulsed with occupancy 3
    nxt(1'b0, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) nxt(1'b1, 1'b1, 1'b0, 32'h0);
    nxt(1'b0, 1'b1, 1'b0, 32'h0);
    chk("mr_ce", {31'b0, rom_ce}, 32'h0);
    chk("mr_vld", {31'b0, id_vld}, 32'h0);
    chk("mr_pc", id_pc, 32'h0);
    chk("mr_is", id_is, 32'h0);
    nxt(1'b1, 1'b1, 1'b0, 32'h0);
    chk("mr_vld1", {31'b0, id_vld}, 32'h0);
    chk("mr_ce1", {31'b0, rom_ce}, 32'h1);
    chk("mr_addr", rom_addr, 32'h0);
    nxt(1'b1, 1'b1, 1'b0, 32'h0);
    chk("mr_addr4", rom_addr, 32'h4);
    nxt(1'b1, 1'b1, 1'b0, 32'h0);
    chk("mr_pc0", id_pc, 32'h0);

    // Latency-3 ROM streaming
    nxt(1'b0, 1'b0, 1'b0, 32'h0);
    lat = 3;
    nxt(1'b0, 1'b0, 1'b0, 32'h0);
    issued = 0; popped = 0; maxo = 0; exp_pc = 32'h0;
    for (int k = 0; k < 40; k++) begin
      nxt(1'b1, 1'b0, 1'b0, 32'h0);
      if (issued - popped > maxo) maxo = issued - popped;
      if (id_vld) begin
        chk("l3_pc", id_pc, exp_pc);
        chk("l3_is", id_is, exp_pc);
        exp_pc += 32'h4;
        popped++;
      end
      if (rom_ce) issued++;
    end
    chk("l3_pops", 32'(popped), 32'd29);
    chk("l3_maxout", 32'(maxo), 32'd4);

    // Latency-3: jmp with two requests in flight
    nxt(1'b0, 1'b0, 1'b0, 32'h0);
    nxt(1'b1, 1'b0, 1'b0, 32'h0);
    nxt(1'b1, 1'b0, 1'b0, 32'h0);
    nxt(1'b1, 1'b0, 1'b1, 32'h100);
    chk("j3_ce", {31'b0, rom_ce}, 32'h0);
    nxt(1'b1, 1'b0, 1'b0, 32'h0);
    chk("j3_addr", rom_addr, 32'h100);
    chk("j3_vld3", {31'b0, id_vld}, 32'h0);
    nxt(1'b1, 1'b0, 1'b0, 32'h0);
    chk("j3_addr4", rom_addr, 32'h104);
    chk("j3_vld4", {31'b0, id_vld}, 32'h0);
    nxt(1'b1, 1'b0, 1'b0, 32'h0);
    chk("j3_vld5", {31'b0, id_vld}, 32'h0);
    nxt(1'b1, 1'b0, 1'b0, 32'h0);
    chk("j3_vld6", {31'b0, id_vld}, 32'h0);
    nxt(1'b1, 1'b0, 1'b0, 32'h0);
    chk("j3_vld7", {31'b0, id_vld}, 32'h1);
    chk("j3_pc", id_pc, 32'h100);
    chk("j3_is", id_is, 32'h100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
